dma_w_buf: RTL
==============

DMA_W_BUF -- requirements
Module: dma_w_buf

Interface
REQ-001 Parameter: BUF_ADDR_W, default 8, log2 of the buffer depth in MIG_BUS_W words; SHALL be >= AXI_LEN_W+1.
REQ-002 Port: clk  input  1  system clock; one clock only, all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  single-cycle job start pulse.
REQ-005 Port: base_addr  input  DDR_ADDR_W  first DDR byte address of the job.
REQ-006 Port: nbursts  input  16  number of bursts in the job.
REQ-007 Port: len  input  AXI_LEN_W  beats per burst minus one.
REQ-008 Port: busy  output  1  job in progress.
REQ-009 Port: done  output  1  single-cycle job-complete pulse.
REQ-010 Port: in_valid  input  1  upstream word valid.
REQ-011 Port: in_ready  output  1  buffer can accept a word.
REQ-012 Port: in_data  input  MIG_BUS_W  upstream word.
REQ-013 Port: in_strb  input  MIG_BUS_W/8  upstream byte strobe; present only with DMA_W_BUF_STRB_EN.
REQ-014 Port: dma_valid  output  1  burst request to the AXI write DMA.
REQ-015 Port: dma_ready  input  1  per-beat consume strobe from the AXI write DMA.
REQ-016 Port: dma_addr  output  DDR_ADDR_W  burst start address.
REQ-017 Port: dma_wdata  output  MIG_BUS_W  beat data.
REQ-018 Port: dma_wstrb  output  MIG_BUS_W/8  beat strobe.
REQ-019 Port: dma_len  output  AXI_LEN_W  latched len.

Function
REQ-020 Buffer: circular FIFO of 2^BUF_ADDR_W words; BUF_ADDR_W+1-bit occupancy counter.
REQ-021 Push: occurs when in_valid && in_ready; in_ready = !full, independent of FSM state.
REQ-022 Pop: one pop per dma_ready cycle.
REQ-023 Simultaneous push and pop: occupancy unchanged; both pointers advance and wrap modulo depth.
REQ-024 Read port: 1-cycle registered read; dma_wdata/dma_wstrb show the head word, updating the cycle after each pop.
REQ-025 FSM states: IDLE, FILL, ISSUE, DONE.
REQ-026 IDLE -> FILL on start; latches len and nbursts; dma_addr <= base_addr; burst counter <= 0.
REQ-027 IDLE -> DONE on start when nbursts == 0.
REQ-028 start is ignored outside IDLE.
REQ-029 FILL -> ISSUE when occupancy >= latched len+1, so a full burst is always buffered before dma_valid.
REQ-030 ISSUE: dma_valid = 1; beat counter counts dma_ready.
REQ-031 ISSUE exit: on the beat with count == len, dma_addr += (len+1)*MIG_BUS_W/8 (wraps at DDR_ADDR_W) and burst counter increments.
REQ-032 ISSUE -> FILL after the last beat if more bursts remain, otherwise -> DONE.
REQ-033 DONE: done = 1 for one cycle, then -> IDLE.
REQ-034 busy = 1 in FILL, ISSUE and DONE.
REQ-035 dma_ready outside ISSUE, or with the buffer empty, is an error condition: no pop, no pointer change.
REQ-036 Residual words left after the job completes are retained for the next job.

Reset
REQ-037 rst asserted: state = IDLE; pointers, occupancy and counters = 0; dma_valid = 0, busy = 0, done = 0; dma_addr, dma_len, dma_wdata, dma_wstrb = 0; in_ready = 1 on the first cycle after release.
REQ-038 rst mid-job: aborts immediately and discards buffered data; no done pulse.

Configuration
REQ-039 Macro DMA_W_BUF_STRB_EN.
- Defined: in_strb exists and is stored per word; dma_wstrb = stored strobe.
- Undefined: in_strb is absent; dma_wstrb is constant all-ones (after the reset value of 0); buffer width = MIG_BUS_W.

Verification
REQ-040 Start, base 0x1000, len=3, nbursts=2; push 8 words D0..D7 -> two dma_valid phases at 0x1000 then 0x1000+4*MIG_BUS_W/8; beats D0..D7 in order; one done pulse.
REQ-041 Fill buffer to depth with no pops -> in_ready=0 at occupancy 256; next in_valid word is not accepted; one pop restores in_ready the next cycle.
REQ-042 len=7; push only 5 words -> dma_valid stays 0; push 3 more -> dma_valid asserts the next cycle.
REQ-043 Push and pop every cycle with occupancy 1 across the pointer wrap 255->0 -> occupancy constant; data order preserved.
REQ-044 nbursts=0 start -> done one cycle later; dma_valid never asserts.
REQ-045 rst during the 2nd beat of a burst -> all outputs reach reset values asynchronously; new start with fresh data behaves per REQ-040.

Source files
------------

// File: rtl/dma_w_buf.sv
// dma_w_buf: circular word buffer feeding an AXI write DMA in full bursts.
// `define DMA_W_BUF_STRB_EN to add in_strb and store a byte strobe with each word.
module dma_w_buf #(
    parameter int BUF_ADDR_W = 8,
    parameter int AXI_LEN_W  = 4,
    parameter int DDR_ADDR_W = 32,
    parameter int MIG_BUS_W  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DDR_ADDR_W-1:0]  base_addr,
    input  logic [15:0]            nbursts,
    input  logic [AXI_LEN_W-1:0]   len,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MIG_BUS_W-1:0]   in_data,
`ifdef DMA_W_BUF_STRB_EN
    input  logic [MIG_BUS_W/8-1:0] in_strb,
`endif
    output logic                   dma_valid,
    input  logic                   dma_ready,
    output logic [DDR_ADDR_W-1:0]  dma_addr,
    output logic [MIG_BUS_W-1:0]   dma_wdata,
    output logic [MIG_BUS_W/8-1:0] dma_wstrb,
    output logic [AXI_LEN_W-1:0]   dma_len
);
    localparam int DEPTH = 1 << BUF_ADDR_W;
    typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;
    state_t state, state_n;
    logic [MIG_BUS_W-1:0] mem [DEPTH];
`ifdef DMA_W_BUF_STRB_EN
    logic [MIG_BUS_W/8-1:0] smem [DEPTH];
`endif
    logic [BUF_ADDR_W-1:0] wr_ptr, rd_ptr, rd_next;
    logic [BUF_ADDR_W:0] count;
    logic [15:0] nb_q, bcnt;
    logic [AXI_LEN_W-1:0] beat;
    logic push, pop, last, byp, enough;
    assign in_ready  = !count[BUF_ADDR_W];
    assign push      = in_valid && in_ready;
    assign pop       = dma_ready && state == ISSUE && count != '0;
    assign last      = pop && beat == dma_len;
    assign rd_next   = rd_ptr + BUF_ADDR_W'(pop);
    // a word written into the slot about to become head must bypass the array
    assign byp       = push && wr_ptr == rd_next;
    assign enough    = count > {{(BUF_ADDR_W+1-AXI_LEN_W){1'b0}}, dma_len};
    assign dma_valid = state == ISSUE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (nbursts == '0) ? DONE : FILL;
            FILL:    if (enough) state_n = ISSUE;
            ISSUE:   if (last) state_n = (bcnt + 16'd1 == nb_q) ? DONE : FILL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dma_addr <= '0;
            dma_len  <= '0;
            nb_q     <= '0;
            bcnt     <= '0;
            beat     <= '0;
        end else if (state == IDLE && start) begin
            dma_addr <= base_addr;
            dma_len  <= len;
            nb_q     <= nbursts;
            bcnt     <= '0;
            beat     <= '0;
        end else if (pop) begin
            beat <= last ? '0 : beat + 1'b1;
            if (last) begin
                dma_addr <= dma_addr + (DDR_ADDR_W'(dma_len) + DDR_ADDR_W'(1)) * DDR_ADDR_W'(MIG_BUS_W / 8);
                bcnt     <= bcnt + 16'd1;
            end
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + BUF_ADDR_W'(push);
            rd_ptr <= rd_next;
            count  <= count + (BUF_ADDR_W+1)'(push) - (BUF_ADDR_W+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) begin
            mem[wr_ptr] <= in_data;
`ifdef DMA_W_BUF_STRB_EN
            smem[wr_ptr] <= in_strb;
`endif
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dma_wdata <= '0;
            dma_wstrb <= '0;
        end else begin
            dma_wdata <= byp ? in_data : mem[rd_next];
`ifdef DMA_W_BUF_STRB_EN
            dma_wstrb <= byp ? in_strb : smem[rd_next];
`else
            dma_wstrb <= '1;
`endif
        end
endmodule
